ped_crossing_ctrl: RTL

Pedestrian-side companion to the stoplight controller. It conditions a raw pedestrian push-button, issues a one-cycle `button` request pulse to the stoplight, and watches the stoplight's `red`/`yellow`/`green` outputs. It grants a timed WALK phase followed by a flashing DON'T-WALK phase only while the stoplight holds red. It sits beside `top` in the stoplight design, driving its `button` input and consuming its lamp outputs.

---
 rtl/ped_pkg.sv | 10 +
 rtl/ped_crossing_ctrl_debounce.sv | 29 ++
 rtl/ped_crossing_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/ped_pkg.sv
// ped_pkg: shared state type, counter width and default timing for the pedestrian crossing controller
package ped_pkg;
  typedef enum logic [1:0] {IDLE, REQUEST, WALK, FLASH} ped_state_t;
  localparam int CNT_W = 8;
  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_WALK = 8;
  localparam int DEF_FLASH = 6;
  localparam int DEF_FLASH_HALF = 2;
  localparam int DEF_RETRY = 32;
endpackage

// File: rtl/ped_crossing_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer and debounce counter emitting a one-cycle press strobe
// clk, nrst (async active-low) | btn_raw: bouncy async button | press: debounced rising-edge strobe
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_raw,
  output logic press
);
  logic s1, s2, level, level_q;
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= 4'd0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      level_q <= level;
      cnt <= !s2 ? 4'd0 : (cnt == 4'(DEBOUNCE_CYCLES)) ? cnt : cnt + 4'd1;
      // level rises on the DEBOUNCE_CYCLES-th consecutive high sample, falls on any low one
      level <= s2 && (cnt >= 4'(DEBOUNCE_CYCLES - 1));
    end
  assign press = level & ~level_q;
endmodule

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian request/WALK/flashing DON'T-WALK controller beside a stoplight
// clk, nrst (async active-low) | btn_raw: raw button | red/yellow/green: stoplight lamps
// button: request pulse | walk, dont_walk: lamps | req_pending | countdown: phase cycles left | light_fault: sticky
module ped_crossing_ctrl import ped_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int WALK_CYCLES = DEF_WALK,
  parameter int FLASH_CYCLES = DEF_FLASH,
  parameter int FLASH_HALF = DEF_FLASH_HALF,
  parameter int RETRY_CYCLES = DEF_RETRY
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_raw,
  input  logic red,
  input  logic yellow,
  input  logic green,
  output logic button,
  output logic walk,
  output logic dont_walk,
  output logic req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic light_fault
);
  ped_state_t state;
  logic press, red_ok, illegal;
  logic [15:0] retry;
  logic [CNT_W-1:0] half;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .nrst(nrst),
    .btn_raw(btn_raw),
    .press(press)
  );
  assign red_ok = red & ~yellow & ~green;
  // odd parity covers one or three lamps lit; three is excluded separately
  assign illegal = ~(red ^ yellow ^ green) | (red & yellow & green);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      button <= 1'b0;
      walk <= 1'b0;
      dont_walk <= 1'b1;
      req_pending <= 1'b0;
      countdown <= '0;
      light_fault <= 1'b0;
      retry <= '0;
      half <= '0;
    end else begin
      button <= 1'b0;
      light_fault <= light_fault | illegal;
      case (state)
        IDLE:
          if (press) begin
            state <= REQUEST;
            button <= 1'b1;
            req_pending <= 1'b1;
            retry <= '0;
          end
        REQUEST:
          if (red_ok) begin
            state <= WALK;
            req_pending <= 1'b0;
            walk <= 1'b1;
            dont_walk <= 1'b0;
            countdown <= CNT_W'(WALK_CYCLES);
          end else if (retry == 16'(RETRY_CYCLES - 1)) begin
            button <= 1'b1;
            retry <= '0;
          end else retry <= retry + 16'd1;
        WALK:
          if (!red_ok) begin
            state <= IDLE;
            walk <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= '0;
          end else if (countdown == CNT_W'(1)) begin
            state <= FLASH;
            walk <= 1'b0;
            countdown <= CNT_W'(FLASH_CYCLES);
            half <= '0;
          end else countdown <= countdown - CNT_W'(1);
        FLASH:
          if (!red_ok || countdown == CNT_W'(1)) begin
            state <= IDLE;
            dont_walk <= 1'b1;
            countdown <= '0;
          end else begin
            countdown <= countdown - CNT_W'(1);
            half <= (half == CNT_W'(FLASH_HALF - 1)) ? '0 : half + CNT_W'(1);
            dont_walk <= (half == CNT_W'(FLASH_HALF - 1)) ? ~dont_walk : dont_walk;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
